// File: rtl/pb_gesture_decoder.sv
// rtl/pb_gesture_decoder.sv - push-button gesture decoder (short/long/double click); define PB_REPEAT_EN for auto-repeat
module pb_gesture_decoder #(
    parameter logic [23:0] LONG_CYCLES   = 24'd12_000_000,
    parameter logic [23:0] DCLICK_CYCLES = 24'd6_000_000,
    parameter logic [23:0] REPEAT_CYCLES = 24'd3_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic pb_state,
    input  logic pb_down,
    input  logic pb_up,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_tick,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        WAIT_SECOND,
        DRAIN,
        LONG_HELD
    } state_t;

    state_t      state, state_nxt;
    logic [23:0] cnt, cnt_nxt, cnt_inc;
    logic        dn, up;
    logic        short_nxt, long_nxt, double_nxt;

    // Simultaneous press and release pulses cancel each other out.
    assign dn      = pb_down & ~pb_up;
    assign up      = pb_up & ~pb_down;
    assign cnt_inc = (&cnt) ? cnt : cnt + 24'd1;
    assign busy    = (state != IDLE);

`ifdef PB_REPEAT_EN
    logic repeat_nxt;
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        double_nxt = 1'b0;
`ifdef PB_REPEAT_EN
        repeat_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (dn)
                    state_nxt = PRESSED;
                else if (pb_state && !up)
                    state_nxt = DRAIN;
            end
            PRESSED: begin
                cnt_nxt = cnt_inc;
                if (up) begin
                    state_nxt = WAIT_SECOND;
                end else if (cnt >= LONG_CYCLES - 24'd1) begin
                    long_nxt  = 1'b1;
                    state_nxt = LONG_HELD;
                end
            end
            WAIT_SECOND: begin
                cnt_nxt = cnt_inc;
                if (dn) begin
                    double_nxt = 1'b1;
                    state_nxt  = DRAIN;
                end else if (cnt >= DCLICK_CYCLES - 24'd1) begin
                    short_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (up || !pb_state)
                    state_nxt = IDLE;
            end
            LONG_HELD: begin
                if (up) begin
                    state_nxt = IDLE;
                end
`ifdef PB_REPEAT_EN
                // Period restarts on each tick, so ticks land every REPEAT_CYCLES.
                else if (cnt >= REPEAT_CYCLES - 24'd1) begin
                    repeat_nxt = 1'b1;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state)
            cnt_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            double_click <= double_nxt;
        end
    end

`ifdef PB_REPEAT_EN
    always_ff @(posedge clk) begin
        if (!reset)
            repeat_tick <= 1'b0;
        else
            repeat_tick <= repeat_nxt;
    end
`else
    assign repeat_tick = 1'b0;
`endif

endmodule

// File: tb/tb_pb_gesture_decoder.sv
// tb/tb_pb_gesture_decoder.sv - scoreboard bench for pb_gesture_decoder
module tb_pb_gesture_decoder;

    localparam logic [3:0] K_NONE  = 4'b0000;
    localparam logic [3:0] K_SHORT = 4'b1000;
    localparam logic [3:0] K_LONG  = 4'b0100;
    localparam logic [3:0] K_DBL   = 4'b0010;
    localparam logic [3:0] K_REP   = 4'b0001;

    logic clk = 1'b0;
    logic reset, pb_state, pb_down, pb_up;
    logic short_press, long_press, double_click, repeat_tick, busy;

    typedef struct {
        logic [3:0] kind;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [3:0] act;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int e0, u0, d0;

    pb_gesture_decoder #(
        .LONG_CYCLES  (24'd16),
        .DCLICK_CYCLES(24'd8),
        .REPEAT_CYCLES(24'd4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pb_state    (pb_state),
        .pb_down     (pb_down),
        .pb_up       (pb_up),
        .short_press (short_press),
        .long_press  (long_press),
        .double_click(double_click),
        .repeat_tick (repeat_tick),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse seen must match the head of the scoreboard in kind and cycle.
    always @(negedge clk) begin
        act = {short_press, long_press, double_click, repeat_tick};
        if (act != 4'b0000) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got kind=%b at cycle %0d, expected no pulse", act, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (act !== mon_e.kind || cyc != mon_e.cyc) begin
                    n_fail++;
                    $display("FAIL pulse: got kind=%b cycle=%0d, expected kind=%b cycle=%0d",
                             act, cyc, mon_e.kind, mon_e.cyc);
                end
            end
        end
    end

    task automatic push_exp(input logic [3:0] kind, input int at);
        exp_t x;
        x.kind = kind;
        x.cyc  = at;
        sb.push_back(x);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Input tasks start at a falling edge; e is the rising edge that samples the pulse.
    task automatic press(input logic [3:0] kind, input int delay, output int e);
        pb_down  = 1'b1;
        pb_state = 1'b1;
        e = cyc + 1;
        if (kind != K_NONE) push_exp(kind, e + delay);
        @(negedge clk);
        pb_down = 1'b0;
    endtask

    task automatic release_pb(input logic [3:0] kind, input int delay, output int e);
        pb_up    = 1'b1;
        pb_state = 1'b0;
        e = cyc + 1;
        if (kind != K_NONE) push_exp(kind, e + delay);
        @(negedge clk);
        pb_up = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, got, want);
        end
    endtask

    initial begin
        reset    = 1'b0;
        pb_state = 1'b0;
        pb_down  = 1'b0;
        pb_up    = 1'b0;
        wait_n(3);
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_outputs", {4'd0, short_press, long_press, double_click, repeat_tick}, 8'd0);
        reset = 1'b1;
        wait_n(2);

        // Short click: release 5 cycles after press, short_press 8 cycles after release.
        press(K_NONE, 0, e0);
        wait_n(4);
        release_pb(K_SHORT, 8, u0);
        wait_n(12);
        chk("short_idle_busy", {7'd0, busy}, 8'd0);

        // Long hold: long_press 16 after press, repeats every 4 after that.
        press(K_LONG, 16, e0);
`ifdef PB_REPEAT_EN
        push_exp(K_REP, e0 + 20);
        push_exp(K_REP, e0 + 24);
`endif
        wait_n(20);
        chk("long_held_busy", {7'd0, busy}, 8'd1);
        wait_n(5);
        release_pb(K_NONE, 0, u0);
        wait_n(12);
        chk("long_idle_busy", {7'd0, busy}, 8'd0);

        // Double click with 3-cycle gaps.
        press(K_NONE, 0, e0);
        wait_n(2);
        release_pb(K_NONE, 0, u0);
        wait_n(2);
        press(K_DBL, 0, d0);
        wait_n(3);
        release_pb(K_NONE, 0, u0);
        wait_n(12);
        chk("dbl_idle_busy", {7'd0, busy}, 8'd0);

        // Release exactly at the long-press threshold, second press at the double-click limit.
        press(K_NONE, 0, e0);
        wait_n(15);
        release_pb(K_NONE, 0, u0);
        chk("edge_wait_second_busy", {7'd0, busy}, 8'd1);
        wait_n(7);
        press(K_DBL, 0, d0);
        wait_n(2);
        release_pb(K_NONE, 0, u0);
        wait_n(12);
        chk("edge_idle_busy", {7'd0, busy}, 8'd0);

        // Reset mid-press at cnt == 10, released with the button still held.
        press(K_NONE, 0, e0);
        wait_n(10);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_busy", {7'd0, busy}, 8'd0);
        chk("midreset_outputs", {4'd0, short_press, long_press, double_click, repeat_tick}, 8'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("drain_busy", {7'd0, busy}, 8'd1);
        release_pb(K_NONE, 0, u0);
        chk("drain_exit_busy", {7'd0, busy}, 8'd0);
        wait_n(20);

        // Simultaneous down and up in IDLE is ignored.
        pb_down  = 1'b1;
        pb_up    = 1'b1;
        pb_state = 1'b0;
        @(negedge clk);
        chk("both_pulses_busy", {7'd0, busy}, 8'd0);
        pb_down = 1'b0;
        pb_up   = 1'b0;
        wait_n(3);
        chk("both_pulses_after", {7'd0, busy}, 8'd0);
        wait_n(10);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_pulses: %0d expected pulses never seen, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
